// File: rtl/countdown_arbiter.sv
// Round-robin scheduler sharing one loadable down-counter among NREQ requesters.
// Optional feature: define COUNTDOWN_ABORT_EN to abort a countdown when its requester drops req.
module countdown_arbiter #(
   parameter int NREQ  = 4,
   parameter int CNT_W = 3
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*CNT_W-1:0]   req_val,
   output logic [NREQ-1:0]         grant,
   output logic                    busy,
   output logic [NREQ-1:0]         done,
   output logic [CNT_W-1:0]        cnt_out
);

   localparam int unsigned N  = NREQ;
   localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, COUNT} state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PW-1:0]     ptr_q, ptr_d;

   logic [CNT_W-1:0]  val_a [NREQ];
   logic              found;
   logic [PW-1:0]     sel;
   logic [PW-1:0]     idx;
   int unsigned       t;

   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         val_a[i] = req_val[i*CNT_W +: CNT_W];
      end
   end

   // First set request at or above ptr, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      t     = 0;
      for (int unsigned i = 0; i < N; i++) begin
         t = 32'(ptr_q) + i;
         if (t >= N) t = t - N;
         idx = PW'(t);
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = '0;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d      = '0;
               grant_d[sel] = 1'b1;
               cnt_d        = val_a[sel];
               ptr_d        = (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
               state_d      = COUNT;
            end else begin
               cnt_d = '0;
            end
         end
         COUNT: begin
`ifdef COUNTDOWN_ABORT_EN
            if ((req & grant_q) == '0) begin
               grant_d = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else
`endif
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               done_d  = grant_q;
               grant_d = '0;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         done_q  <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant   = grant_q;
   assign done    = done_q;
   assign cnt_out = cnt_q;
   assign busy    = (state_q == COUNT);

endmodule

// File: tb/tb_countdown_arbiter.sv
// Scoreboard bench for countdown_arbiter (NREQ=4, CNT_W=3); honours COUNTDOWN_ABORT_EN.
module tb_countdown_arbiter;

   localparam int NREQ  = 4;
   localparam int CNT_W = 3;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*CNT_W-1:0] req_val = '0;
   logic [NREQ-1:0]       grant;
   logic                  busy;
   logic [NREQ-1:0]       done;
   logic [CNT_W-1:0]      cnt_out;

   countdown_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .req_val (req_val),
      .grant   (grant),
      .busy    (busy),
      .done    (done),
      .cnt_out (cnt_out)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   typedef struct {
      int unsigned idx;
      int unsigned val;
   } exp_t;

   exp_t sb[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: tracks each grant window and scores it against the queue when done pulses.
   logic [NREQ-1:0]  prev_g = '0;
   logic [NREQ-1:0]  seg_g = '0;
   logic [CNT_W-1:0] prev_cnt = '0;
   int unsigned      seg_len = 0;
   int unsigned      seg_first = 0;
   exp_t             e_mon;

   always @(negedge clk) begin
      if (grant != '0) begin
         if (prev_g == '0) begin
            seg_g     = grant;
            seg_len   = 1;
            seg_first = 32'(cnt_out);
            check_eq("grant_onehot", 32'($countones(grant)), 32'd1);
         end else begin
            seg_len++;
            check_eq("grant_hold", 32'(grant), 32'(seg_g));
            check_eq("cnt_dec", 32'(cnt_out), 32'(prev_cnt) - 32'd1);
         end
      end
      if (done != '0) begin
         if (sb.size() == 0) begin
            check_eq("unexp_done", 32'(done), 32'd0);
         end else begin
            e_mon = sb.pop_front();
            check_eq("done_vec", 32'(done), 32'd1 << e_mon.idx);
            check_eq("grant_who", 32'(seg_g), 32'd1 << e_mon.idx);
            check_eq("grant_len", seg_len, e_mon.val + 1);
            check_eq("cnt_first", seg_first, e_mon.val);
            check_eq("done_gap", 32'(grant), 32'd0);
            check_eq("done_cnt", 32'(cnt_out), 32'd0);
         end
      end
      prev_g   = grant;
      prev_cnt = cnt_out;
   end

   task automatic push_exp(input int unsigned idx, input int unsigned val);
      exp_t e;
      e.idx = idx;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic wait_sb_empty(input int unsigned budget);
      int unsigned n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_eq("sb_drain", sb.size(), 32'd0);
   endtask

   task automatic wait_cnt(input logic [CNT_W-1:0] v, input int unsigned budget);
      int unsigned n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!(grant != '0 && cnt_out == v) && n < budget);
      check_eq("wait_cnt", 32'(cnt_out), 32'(v));
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset_n = 1'b0;
      req     = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_grant"}, 32'(grant), 32'd0);
      check_eq({tag, "_done"}, 32'(done), 32'd0);
      check_eq({tag, "_cnt"}, 32'(cnt_out), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with every requester asking.
      req     = 4'b1111;
      req_val = '0;
      repeat (3) begin
         @(negedge clk);
         check_all_zero("rst");
      end
      push_exp(0, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("rel_grant", 32'(grant), 32'h1);
      check_eq("rel_busy", 32'(busy), 32'd1);
      #1 req = '0;
      wait_sb_empty(10);

      // Single request, value 5.
      reset_dut();
      req_val = '0;
      req_val[2*CNT_W +: CNT_W] = 3'd5;
      req = 4'b0100;
      push_exp(2, 5);
      wait_sb_empty(40);
      req = '0;

      // Round-robin over 0,1,3.
      reset_dut();
      req_val = {4{3'd1}};
      req = 4'b1011;
      push_exp(0, 1);
      push_exp(1, 1);
      push_exp(3, 1);
      push_exp(0, 1);
      push_exp(1, 1);
      wait_sb_empty(60);
      req = '0;

      // Zero and maximum load values.
      reset_dut();
      req_val = '0;
      req = 4'b0001;
      push_exp(0, 0);
      wait_sb_empty(20);
      req_val[1*CNT_W +: CNT_W] = 3'd7;
      req = 4'b0010;
      push_exp(1, 7);
      wait_sb_empty(40);
      req = '0;
      repeat (2) @(negedge clk);
      check_all_zero("idle");

      // Reset mid-count discards the countdown and the pointer.
      reset_dut();
      req_val = '0;
      req_val[1*CNT_W +: CNT_W] = 3'd6;
      req = 4'b0010;
      wait_cnt(3'd3, 40);
      reset_n = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      req     = 4'b1111;
      req_val = '0;
      @(negedge clk);
      push_exp(0, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("ptr_reset", 32'(grant), 32'h1);
      #1 req = '0;
      wait_sb_empty(10);

      // Drop the granted request mid-count.
      reset_dut();
      req_val = '0;
      req_val[0*CNT_W +: CNT_W] = 3'd6;
      req_val[2*CNT_W +: CNT_W] = 3'd2;
      req = 4'b0101;
`ifdef COUNTDOWN_ABORT_EN
      push_exp(2, 2);
`else
      push_exp(0, 6);
      push_exp(2, 2);
`endif
      wait_cnt(3'd4, 40);
      req = 4'b0100;
`ifdef COUNTDOWN_ABORT_EN
      @(negedge clk);
      check_all_zero("abort");
      @(negedge clk);
      check_eq("abort_next", 32'(grant), 32'h4);
`endif
      wait_sb_empty(40);
      req = '0;
      repeat (3) @(negedge clk);
      check_eq("final_done", 32'(done), 32'd0);
      check_eq("final_sb", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/countdown_arbiter.md
# countdown_arbiter

Round-robin scheduler that shares one loadable down-counter among several requesters. Each requester asks for a countdown of a given length. The arbiter grants one requester at a time, loads the shared counter with that requester's value, and counts to zero. It then pulses that requester's `done` and moves on to the next requester. It sits between the requesting control blocks and the counter resource, as the sequencing layer over the loadable down-counter datapath.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `CNT_W`, default 3: counter width in bits.

- `clk`: input, 1 bit. Single clock, rising edge.
- `reset_n`: input, 1 bit. Synchronous, active-low reset.
- `req`: input, NREQ bits. Per-requester request level.
- `req_val`: input, NREQ*CNT_W bits. Load value; requester i uses bits [i*CNT_W +: CNT_W].
- `grant`: output, NREQ bits. One-hot; high while that requester owns the counter.
- `busy`: output, 1 bit. High in COUNT state.
- `done`: output, NREQ bits. One-cycle pulse to the requester whose countdown completed.
- `cnt_out`: output, CNT_W bits. Current counter value.

## Operation
- Reset (reset_n=0 at an edge):
  - state=IDLE.
  - grant, done, cnt_out and busy all 0.
  - Round-robin pointer ptr=0.
  - Reset overrides everything, including mid-count: the active countdown is discarded and no done is issued.
- States: IDLE and COUNT.
- IDLE:
  - If req≠0, select the first set bit searching from ptr upward, wrapping modulo NREQ. Call it index s.
  - At the edge: grant<=onehot(s), count<=req_val[s], ptr<=(s+1) mod NREQ, state<=COUNT.
  - If req=0, stay in IDLE with count=0.
- COUNT:
  - If count≠0: count<=count-1 at each edge.
  - If count==0: at the edge, done<=grant for one cycle, grant<=0, state<=IDLE.
  - No wrap-around: the counter never decrements below 0.
- Values and widths:
  - The load value is used unsigned, exactly as given, with no saturation.
  - A value of 0 is legal and yields a 1-cycle grant.
- Fairness: after serving index s, index s+1 has top priority. No requester waits more than NREQ-1 services.
- Requests:
  - A `req` that changes while not granted is sampled only in IDLE.
  - `req_val` is sampled only at the grant edge; later changes are ignored.
- Simultaneous events:
  - The done cycle is an IDLE cycle, so a new grant appears on the following edge.
  - The requester just served may be re-granted only if no other requester is pending.

## Timing
- Latency from req sampled in IDLE to grant high: 1 cycle.
- Grant duration for load value V: exactly V+1 cycles. cnt_out shows V, V-1, …, 0 during those cycles.
- done rises in the cycle after grant falls and lasts 1 cycle.
- Gap between consecutive grants: 1 cycle (the done/IDLE cycle).
- busy equals (state==COUNT), equivalently |grant.
- All outputs are registered.

## Configuration
- `COUNTDOWN_ABORT_EN`:
  - Defined: in COUNT, if req[s] of the granted requester is 0 at an edge, the countdown aborts. grant<=0, count<=0, state<=IDLE, and no done pulse. ptr still advances (it was already updated at grant).
  - Undefined: req is ignored once granted, and every granted countdown runs to completion with its done pulse.

## Test plan
(NREQ=4, CNT_W=3 unless stated.)
- **Reset:** hold reset_n=0 for 3 cycles with req=4'b1111 -> grant, done, cnt_out and busy all stay 0. Release -> grant=4'b0001 one cycle later.
- **Single request:** req=4'b0100, req_val[2]=5 -> grant=4'b0100 for 6 cycles, cnt_out 5→0, then done=4'b0100 for 1 cycle, then grant=0.
- **Round-robin:** req=4'b1011 held, all values 1 -> grant order 0, 1, 3, 0, 1, …; each grant lasts 2 cycles with a 1-cycle gap.
- **Zero and maximum values:**
  - req_val=0 -> 1-cycle grant, then done.
  - req_val=7 -> 8-cycle grant, and cnt_out never wraps to 7 after 0.
- **Reset mid-count:** req_val[1]=6 granted; assert reset_n=0 when cnt_out=3 -> all outputs 0 on the next cycle, no done[1], ptr back to 0.
- **Abort (COUNTDOWN_ABORT_EN defined):** req_val[0]=6; drop req[0] when cnt_out=4 -> grant=0 next cycle, done stays 0, pending req[2] granted on the following edge. Without the macro, the same stimulus gives full completion with done=4'b0001.
